sc_io_peripheral: RTL and testbench



---
 rtl/sc_io_peripheral.sv | 185 ++++++++++++++++++
 tb/tb_sc_io_peripheral.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_io_peripheral.sv
// Board-side I/O peripheral for the single-cycle computer: debounced switches and keys
// with a key0 press counter feeding in_port0/1, and an 8-digit multiplexed hex display of out_port0.
module sc_io_peripheral #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_CYCLES     = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] out_port0,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_ONE  = SW'(1);

    // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Bits [9:0] are switches, [13:10] are keys inverted so 1 means pressed.
    logic [13:0]      raw_s;
    logic [13:0]      meta_r;
    logic [13:0]      sync_r;
    logic [TW-1:0]    tick_cnt_r;
    logic             tick_s;
    logic [13:0][2:0] hist_r;
    logic [13:0][2:0] hist_next_s;
    logic [13:0]      db_r;
    logic [13:0]      db_next_s;
    logic             key0_prev_r;
    logic [15:0]      press_cnt_r;

    logic [SW-1:0]    scan_cnt_r;
    logic [SW-1:0]    scan_cnt_next_s;
    logic             scan_wrap_s;
    logic [2:0]       digit_r;
    logic [2:0]       digit_next_s;
    logic [31:0]      disp_r;
    logic [31:0]      disp_next_s;
    logic [31:0]      disp_shift_s;
    logic             load_r;
    logic [7:0]       an_next_s;
    logic [6:0]       seg_next_s;

    assign raw_s  = {~key, sw};
    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Two-flop synchroniser on every raw switch and key input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= 14'd0;
            sync_r <= 14'd0;
        end else begin
            meta_r <= raw_s;
            sync_r <= meta_r;
        end
    end

    // Debounce sample-tick counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
        end
    end

    // Next history per bit; only three agreeing samples change the debounced level.
    always_comb begin
        hist_next_s = hist_r;
        db_next_s   = db_r;
        for (int i = 0; i < 14; i++) begin
            hist_next_s[i] = {hist_r[i][1:0], sync_r[i]};
            if (hist_next_s[i] == 3'b111) begin
                db_next_s[i] = 1'b1;
            end else if (hist_next_s[i] == 3'b000) begin
                db_next_s[i] = 1'b0;
            end else begin
                db_next_s[i] = db_r[i];
            end
        end
    end

    // History and debounced level advance only on the sample tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_r <= '0;
            db_r   <= 14'd0;
        end else if (tick_s) begin
            hist_r <= hist_next_s;
            db_r   <= db_next_s;
        end
    end

    // Key0 press counter, counting debounced 0->1 edges only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key0_prev_r <= 1'b0;
            press_cnt_r <= 16'd0;
        end else begin
            key0_prev_r <= db_r[10];
            if (db_r[10] && !key0_prev_r) begin
                press_cnt_r <= press_cnt_r + 16'd1;
            end
        end
    end

    // Registered input-port words seen by the CPU.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_port0 <= 32'd0;
            in_port1 <= 32'd0;
        end else begin
            in_port0 <= {22'd0, db_r[9:0]};
            in_port1 <= {press_cnt_r, 12'd0, db_r[13:10]};
        end
    end

    // Scan sequencing; the display word is only swapped at a frame boundary.
    always_comb begin
        scan_wrap_s     = (scan_cnt_r == SCAN_LAST);
        scan_cnt_next_s = scan_wrap_s ? {SW{1'b0}} : (scan_cnt_r + SCAN_ONE);
        digit_next_s    = scan_wrap_s ? (digit_r + 3'd1) : digit_r;
        if (load_r || (scan_wrap_s && (digit_r == 3'd7))) begin
            disp_next_s = out_port0;
        end else begin
            disp_next_s = disp_r;
        end
        disp_shift_s = disp_next_s >> {digit_next_s, 2'b00};
        an_next_s    = ~(8'd1 << digit_next_s);
        seg_next_s   = hex_to_seg(disp_shift_s[3:0]);
    end

    // Scan state plus an/seg registered together so they always switch in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt_r <= '0;
            digit_r    <= 3'd0;
            disp_r     <= 32'd0;
            load_r     <= 1'b1;
            an         <= 8'hFE;
            seg        <= 7'h40;
        end else begin
            scan_cnt_r <= scan_cnt_next_s;
            digit_r    <= digit_next_s;
            disp_r     <= disp_next_s;
            load_r     <= 1'b0;
            an         <= an_next_s;
            seg        <= seg_next_s;
        end
    end

endmodule

// File: tb/tb_sc_io_peripheral.sv
// Directed self-checking bench for sc_io_peripheral with short debounce and scan periods.
module tb_sc_io_peripheral;

    logic        clock;
    logic        reset;
    logic [31:0] out_port0;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [7:0]  an;
    logic [6:0]  seg;

    int vectors;
    int miscompares;

    // Expected segments for digits 0..7 of 32'h1234ABCD: d C b A 4 3 2 1.
    logic [6:0] exp_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [7:0] exp_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    sc_io_peripheral #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .out_port0(out_port0),
        .sw(sw),
        .key(key),
        .in_port0(in_port0),
        .in_port1(in_port1),
        .an(an),
        .seg(seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        int hit;
        reset = 1'b1; sw = 10'd0; key = 4'hF; out_port0 = 32'h1234ABCD;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        sw = 10'h3FF;
        repeat (30) @(negedge clock);
        vectors++;
        if (in_port0 !== 32'h3FF) begin
            miscompares++;
            $display("FAIL pre_reset_in0 got %h want %h", in_port0, 32'h3FF);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (in_port0 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_in0 got %h want %h", in_port0, 32'd0);
        end
        vectors++;
        if (in_port1 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_in1 got %h want %h", in_port1, 32'd0);
        end
        vectors++;
        if (an !== 8'hFE) begin
            miscompares++;
            $display("FAIL reset_an got %h want %h", an, 8'hFE);
        end
        vectors++;
        if (seg !== 7'h40) begin
            miscompares++;
            $display("FAIL reset_seg got %h want %h", seg, 7'h40);
        end
        @(negedge clock);
        reset = 1'b0;
        hit = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (in_port0 === 32'h3FF) begin
                hit = i;
                break;
            end
        end
        vectors++;
        if (hit == 0 || hit > 15) begin
            miscompares++;
            $display("FAIL reset_latency got %0d cycles want 1..15", hit);
        end
    endtask

    task automatic test_glitch();
        logic leaked;
        sw = 10'd0;
        repeat (20) @(negedge clock);
        vectors++;
        if (in_port0 !== 32'd0) begin
            miscompares++;
            $display("FAIL glitch_idle got %h want %h", in_port0, 32'd0);
        end
        sw = 10'h001;
        repeat (5) @(negedge clock);
        sw = 10'd0;
        leaked = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (in_port0 !== 32'd0) leaked = 1'b1;
        end
        vectors++;
        if (leaked !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_reject got leaked=%0d want 0", leaked);
        end
        sw = 10'h001;
        repeat (20) @(negedge clock);
        vectors++;
        if (in_port0 !== 32'd1) begin
            miscompares++;
            $display("FAIL glitch_hold got %h want %h", in_port0, 32'd1);
        end
        sw = 10'd0;
        repeat (20) @(negedge clock);
    endtask

    task automatic test_press_count();
        for (int p = 0; p < 3; p++) begin
            key = 4'hE;
            repeat (20) @(negedge clock);
            vectors++;
            if (in_port1[3:0] !== 4'h1) begin
                miscompares++;
                $display("FAIL press_key_down got %h want %h", in_port1[3:0], 4'h1);
            end
            key = 4'hF;
            repeat (20) @(negedge clock);
            vectors++;
            if (in_port1[3:0] !== 4'h0) begin
                miscompares++;
                $display("FAIL press_key_up got %h want %h", in_port1[3:0], 4'h0);
            end
        end
        vectors++;
        if (in_port1[31:16] !== 16'd3) begin
            miscompares++;
            $display("FAIL press_count got %h want %h", in_port1[31:16], 16'd3);
        end
    endtask

    task automatic test_wrap();
        @(negedge clock);
        force dut.press_cnt_r = 16'hFFFF;
        @(negedge clock);
        release dut.press_cnt_r;
        repeat (2) @(negedge clock);
        vectors++;
        if (in_port1[31:16] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload got %h want %h", in_port1[31:16], 16'hFFFF);
        end
        key = 4'hE;
        repeat (20) @(negedge clock);
        key = 4'hF;
        repeat (20) @(negedge clock);
        vectors++;
        if (in_port1[31:16] !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_count got %h want %h", in_port1[31:16], 16'h0000);
        end
    endtask

    task automatic test_display();
        int d;
        out_port0 = 32'h1234ABCD;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        // Each digit lasts two cycles; after edge k the lit digit is (k/2) mod 8.
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            d = (k / 2) % 8;
            vectors++;
            if (an !== exp_an[d] || seg !== exp_seg[d]) begin
                miscompares++;
                $display("FAIL display_k%0d got an=%h seg=%h want an=%h seg=%h",
                         k, an, seg, exp_an[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_tearing();
        int d;
        logic [6:0] want_seg;
        out_port0 = 32'h1234ABCD;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        vectors++;
        if (an !== 8'hF7) begin
            miscompares++;
            $display("FAIL tear_at_d3 got %h want %h", an, 8'hF7);
        end
        out_port0 = 32'hFFFFFFFF;
        for (int k = 7; k <= 17; k++) begin
            @(negedge clock);
            d = (k / 2) % 8;
            want_seg = (k >= 16) ? 7'h0E : exp_seg[d];
            vectors++;
            if (an !== exp_an[d] || seg !== want_seg) begin
                miscompares++;
                $display("FAIL tear_k%0d got an=%h seg=%h want an=%h seg=%h",
                         k, an, seg, exp_an[d], want_seg);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sw          = 10'd0;
        key         = 4'hF;
        out_port0   = 32'd0;
        test_reset();
        test_glitch();
        test_press_count();
        test_wrap();
        test_display();
        test_tearing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
